sdram_burst_reader: RTL

SDRAM_BURST_READER -- requirements
Module: sdram_burst_reader

---
 rtl/sd_rd_pkg.sv | 28 ++
 rtl/sd_rd_fifo.sv | 58 +++++
 rtl/sdram_burst_reader.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sd_rd_pkg.sv
// rtl/sd_rd_pkg.sv - shared widths, FSM encoding and word-store helper; BYTE_SWAP_EN selects byte-swapped storage
package sd_rd_pkg;

  localparam int ADDR_W     = 24;
  localparam int DATA_W     = 16;
  localparam int CNT_W      = 10;
  localparam int FIFO_DEPTH = 16;
  localparam int PTR_W      = 4;
  localparam int LEVEL_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STALL = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Word as it is written into the FIFO (optionally byte swapped)
  function automatic logic [DATA_W-1:0] store_word(input logic [DATA_W-1:0] d);
`ifdef BYTE_SWAP_EN
    return {d[7:0], d[15:8]};
`else
    return d;
`endif
  endfunction

endpackage

// File: rtl/sd_rd_fifo.sv
// rtl/sd_rd_fifo.sv - 16x16 synchronous first-word fall-through FIFO with occupancy output
module sd_rd_fifo
  import sd_rd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic [LEVEL_W-1:0] level
);

  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] level_q;
  logic               pop_ok;
  logic               push_ok;

  // A pop on an empty FIFO is dropped; a push into a full FIFO only lands if a pop frees a slot
  assign pop_ok  = pop && (level_q != '0);
  assign push_ok = push && ((level_q != LEVEL_W'(FIFO_DEPTH)) || pop_ok);

  assign level = level_q;
  assign empty = (level_q == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

  // Storage array; no reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; reset flushes the contents
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LEVEL_W'(1);
        2'b01:   level_q <= level_q - LEVEL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/sdram_burst_reader.sv
// rtl/sdram_burst_reader.sv - burst read engine: one-outstanding SD reads into a host FWFT FIFO (BYTE_SWAP_EN via sd_rd_pkg)
module sdram_burst_reader
  import sd_rd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_addr,
  input  logic [CNT_W-1:0]   word_cnt,
  output logic               busy,
  output logic               done,
  output logic               mem_rd_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic               mem_rd_valid,
  input  logic [DATA_W-1:0]  mem_rd_data,
  input  logic               host_rd,
  output logic [DATA_W-1:0]  host_q,
  output logic               fifo_empty,
  output logic [LEVEL_W-1:0] fifo_level
);

  state_t             state;
  logic [ADDR_W-1:0]  addr_cnt;
  logic [CNT_W-1:0]   remaining;
  logic               push;
  logic [DATA_W-1:0]  push_data;
  logic               pop_eff;
  logic               fifo_full;
  logic [LEVEL_W:0]   level_after_push;

  // Read data is only accepted while a request is outstanding
  assign push      = (state == ST_WAIT) && mem_rd_valid;
  assign push_data = store_word(mem_rd_data);
  assign pop_eff   = host_rd && !fifo_empty;
  assign fifo_full = (fifo_level == LEVEL_W'(FIFO_DEPTH));

  // Occupancy after this cycle's push, accounting for a simultaneous host pop
  assign level_after_push = {1'b0, fifo_level} + (LEVEL_W+1)'(1) - (LEVEL_W+1)'(pop_eff);

  sd_rd_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (host_rd),
    .head      (host_q),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Burst sequencer with registered busy/done/request outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_rd_req <= 1'b0;
      mem_addr   <= '0;
      addr_cnt   <= '0;
      remaining  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_cnt  <= start_addr;
            remaining <= word_cnt;
            busy      <= 1'b1;
            if (word_cnt == '0) begin
              state <= ST_DONE;
            end else if (fifo_full && !pop_eff) begin
              // leftover words from an earlier burst fill the FIFO
              state <= ST_STALL;
            end else begin
              state      <= ST_ISSUE;
              mem_rd_req <= 1'b1;
              mem_addr   <= start_addr;
            end
          end
        end
        ST_ISSUE: begin
          if (mem_ack) begin
            mem_rd_req <= 1'b0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rd_valid) begin
            addr_cnt  <= addr_cnt + ADDR_W'(1);
            remaining <= remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
              state <= ST_DONE;
            end else if (level_after_push == (LEVEL_W+1)'(FIFO_DEPTH)) begin
              state <= ST_STALL;
            end else begin
              state      <= ST_ISSUE;
              mem_rd_req <= 1'b1;
              mem_addr   <= addr_cnt + ADDR_W'(1);
            end
          end
        end
        ST_STALL: begin
          if (!fifo_full) begin
            state      <= ST_ISSUE;
            mem_rd_req <= 1'b1;
            mem_addr   <= addr_cnt;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          mem_rd_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
